// File: rtl/cmd_frame_machine_pkg.sv
// Opcode constants and FSM state type shared by the command frame machine.
package cmd_pkg;

    localparam logic [7:0] OP_SW_RST = 8'h00;
    localparam logic [7:0] OP_ENC    = 8'h05;
    localparam logic [7:0] OP_DEC    = 8'h0A;
    localparam logic [7:0] OP_RECV   = 8'h50;
    localparam logic [7:0] OP_STORE  = 8'h55;
    localparam logic [7:0] OP_LOAD   = 8'h5A;
    localparam logic [7:0] OP_DIN    = 8'hA0;
    localparam logic [7:0] OP_GO     = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_SLOT_WAIT,
        ST_START_WAIT
    } state_t;

endpackage

// File: rtl/cmd_frame_machine_if.sv
// Byte-command input and AES-core output bundle of the command frame machine.
interface cmd_frame_machine_if #(
    parameter int DATA_BYTES = 16,
    parameter int SLOT_W     = 2
);
    logic [7:0]              cmd_data;
    logic                    cmd_rdy;
    logic                    core_busy;
    logic [DATA_BYTES*8-1:0] kout;
    logic [DATA_BYTES*8-1:0] dout;
    logic [SLOT_W-1:0]       key_sel;
    logic                    key_ready;
    logic                    din_ready;
    logic                    start;
    logic                    rst_sw;
    logic                    err;
    logic                    enc_dec;

    modport master (
        output cmd_data, cmd_rdy, core_busy,
        input  kout, dout, key_sel, key_ready, din_ready, start, rst_sw, err, enc_dec
    );

    modport slave (
        input  cmd_data, cmd_rdy, core_busy,
        output kout, dout, key_sel, key_ready, din_ready, start, rst_sw, err, enc_dec
    );
endinterface

// File: rtl/cmd_frame_machine_edge_det.sv
// Turns each rising edge of the UART byte-ready level into one accept pulse,
// capturing the byte alongside so it is stable when the FSM consumes it.
module cmd_edge_det (
    input  logic       clk,
    input  logic       rst_h,
    input  logic       rdy_i,
    input  logic [7:0] data_i,
    output logic       accept_o,
    output logic [7:0] data_o
);
    logic       rdy_q;
    logic       accept_q, accept_d;
    logic [7:0] data_q;

    assign accept_d = rdy_i & ~rdy_q;

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            rdy_q    <= 1'b0;
            accept_q <= 1'b0;
            data_q   <= '0;
        end else begin
            rdy_q    <= rdy_i;
            accept_q <= accept_d;
            if (accept_d) data_q <= data_i;
        end
    end

    assign accept_o = accept_q;
    assign data_o   = data_q;
endmodule

// File: rtl/cmd_frame_machine.sv
// Command frame decoder: assembles UART bytes into key/data blocks for an AES core.
// Define CMD_TIMEOUT_EN to abort RECV/SLOT_WAIT after TIMEOUT_CYC idle cycles.
module cmd_frame_machine
    import cmd_pkg::*;
#(
    parameter int DATA_BYTES  = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic                clk,
    input logic                rst_h,
    cmd_frame_machine_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int DW     = DATA_BYTES * 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BYTES - 1);

    state_t state_q, state_d;

    logic                          accept;
    logic [7:0]                    byte_q;
    logic [DW-1:0]                 recv_q, recv_d;
    logic [DW-1:0]                 din_q, din_d;
    logic [NUM_SLOTS-1:0][DW-1:0]  slot_q, slot_d;
    logic [DW-1:0]                 kout_q, kout_d;
    logic [DW-1:0]                 dout_q, dout_d;
    logic [SLOT_W-1:0]             key_sel_q, key_sel_d;
    logic                          enc_dec_q, enc_dec_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [7:0]                    op_q, op_d;
    logic                          key_ready_q, key_ready_d;
    logic                          din_ready_q, din_ready_d;
    logic                          start_q, start_d;
    logic                          rst_sw_q, rst_sw_d;
    logic                          err_q, err_d;
    logic [SLOT_W-1:0]             slot_idx;
    logic                          slot_oob;
    logic                          tmo_hit;

    cmd_edge_det u_edge_det (
        .clk      (clk),
        .rst_h    (rst_h),
        .rdy_i    (bus.cmd_rdy),
        .data_i   (bus.cmd_data),
        .accept_o (accept),
        .data_o   (byte_q)
    );

    assign slot_idx = byte_q[SLOT_W-1:0];
    assign slot_oob = (32'(byte_q) >= 32'(NUM_SLOTS));

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (!accept && (state_q == ST_RECV || state_q == ST_SLOT_WAIT))
            tmo_d = tmo_q + 1'b1;
    end

    assign tmo_hit = (tmo_d == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (byte_q == OP_RECV)
                        state_d = ST_RECV;
                    else if (byte_q == OP_STORE || byte_q == OP_LOAD)
                        state_d = ST_SLOT_WAIT;
                    else if (byte_q == OP_GO && !bus.core_busy)
                        state_d = ST_START_WAIT;
                end
            end
            ST_RECV:       if (accept && cnt_q == '0) state_d = ST_IDLE;
            ST_SLOT_WAIT:  if (accept) state_d = ST_IDLE;
            ST_START_WAIT: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        if (tmo_hit) state_d = ST_IDLE;
    end

    // Stores and loads share one SLOT_WAIT byte, so a load always sees the
    // pre-write slot contents through slot_q.
    always_comb begin
        recv_d      = recv_q;
        din_d       = din_q;
        slot_d      = slot_q;
        kout_d      = kout_q;
        dout_d      = dout_q;
        key_sel_d   = key_sel_q;
        enc_dec_d   = enc_dec_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        key_ready_d = 1'b0;
        din_ready_d = 1'b0;
        start_d     = 1'b0;
        rst_sw_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (byte_q)
                        OP_SW_RST: begin
                            rst_sw_d  = 1'b1;
                            recv_d    = '0;
                            enc_dec_d = 1'b0;
                        end
                        OP_ENC:   enc_dec_d = 1'b0;
                        OP_DEC:   enc_dec_d = 1'b1;
                        OP_RECV:  cnt_d = CNT_MAX;
                        OP_STORE,
                        OP_LOAD:  op_d = byte_q;
                        OP_DIN:   din_d = recv_q;
                        OP_GO: begin
                            if (bus.core_busy) begin
                                err_d = 1'b1;
                            end else begin
                                dout_d      = din_q;
                                din_ready_d = 1'b1;
                            end
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_RECV: begin
                if (accept) begin
                    recv_d[int'(cnt_q)*8 +: 8] = byte_q;
                    cnt_d = (cnt_q == '0) ? CNT_MAX : cnt_q - 1'b1;
                end
            end
            ST_SLOT_WAIT: begin
                if (accept) begin
                    if (slot_oob) begin
                        err_d = 1'b1;
                    end else if (op_q == OP_STORE) begin
                        slot_d[slot_idx] = recv_q;
                    end else begin
                        kout_d      = slot_q[slot_idx];
                        key_sel_d   = slot_idx;
                        key_ready_d = 1'b1;
                    end
                end
            end
            ST_START_WAIT: begin
                start_d = 1'b1;
                if (accept) err_d = 1'b1;
            end
            default: ;
        endcase
        if (tmo_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            recv_q      <= '0;
            din_q       <= '0;
            slot_q      <= '0;
            kout_q      <= '0;
            dout_q      <= '0;
            key_sel_q   <= '0;
            enc_dec_q   <= 1'b0;
            cnt_q       <= CNT_MAX;
            op_q        <= '0;
            key_ready_q <= 1'b0;
            din_ready_q <= 1'b0;
            start_q     <= 1'b0;
            rst_sw_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            recv_q      <= recv_d;
            din_q       <= din_d;
            slot_q      <= slot_d;
            kout_q      <= kout_d;
            dout_q      <= dout_d;
            key_sel_q   <= key_sel_d;
            enc_dec_q   <= enc_dec_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            key_ready_q <= key_ready_d;
            din_ready_q <= din_ready_d;
            start_q     <= start_d;
            rst_sw_q    <= rst_sw_d;
            err_q       <= err_d;
        end
    end

    assign bus.kout      = kout_q;
    assign bus.dout      = dout_q;
    assign bus.key_sel   = key_sel_q;
    assign bus.enc_dec   = enc_dec_q;
    assign bus.key_ready = key_ready_q;
    assign bus.din_ready = din_ready_q;
    assign bus.start     = start_q;
    assign bus.rst_sw    = rst_sw_q;
    assign bus.err       = err_q;
endmodule

// File: doc/cmd_frame_machine.md
CMD_FRAME_MACHINE -- requirements
Module: cmd_frame_machine

Interface
REQ-001 Parameter DATA_BYTES, default 16, payload length in bytes for DATA frames and the width of kout/dout divided by 8.
REQ-002 Parameter NUM_SLOTS, default 4, number of stored key slots; SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-003 Parameter TIMEOUT_CYC, default 65535, idle-byte timeout in clk cycles; used only under CMD_TIMEOUT_EN.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst_h  in  1  reset, asynchronous, active-high.
REQ-006 cmd_data  in  8  command or payload byte, valid while cmd_rdy is high.
REQ-007 cmd_rdy  in  1  byte-ready level from the UART; one byte per rising edge.
REQ-008 core_busy  in  1  AES core is processing and cannot accept new data.
REQ-009 kout  out  DATA_BYTES*8  key presented to the core.
REQ-010 dout  out  DATA_BYTES*8  data block presented to the core.
REQ-011 key_sel  out  SLOT_W  slot index of the current kout.
REQ-012 key_ready, din_ready, start, rst_sw, err  out  1 each  single-cycle pulses.
REQ-013 enc_dec  out  1  mode: 0 = encrypt, 1 = decrypt.

Function
REQ-014 A byte SHALL be accepted on edge E+1, where E is the first edge at which cmd_rdy is sampled 1 after being sampled 0; one accepted byte per cmd_rdy rising edge.
REQ-015 FSM states SHALL be IDLE, RECV, SLOT_WAIT, START_WAIT; all other behaviour is encoded in registered pulses.
REQ-016 In IDLE, accepted opcodes SHALL act as follows:
- 0x00: rst_sw pulses next cycle; recv buffer and enc_dec clear.
- 0x05: enc_dec<=0.
- 0x0A: enc_dec<=1.
- 0x50: byte counter loads DATA_BYTES-1; go to RECV.
- 0x55, 0x5A: latch opcode; go to SLOT_WAIT.
- 0xA0: din <= recv buffer.
- 0xA5: see REQ-020.
REQ-017 Any other opcode in IDLE SHALL pulse err for one cycle and remain in IDLE.
REQ-018 In RECV, each accepted byte SHALL be written to recv[cnt*8+7 -: 8] and cnt SHALL decrement, so the first byte lands in the MSB; after the byte with cnt==0 the FSM returns to IDLE.
REQ-019 In SLOT_WAIT, the accepted byte SHALL be a slot index s, and the FSM returns to IDLE:
- s >= NUM_SLOTS: err pulses; no other effect.
- Opcode 0x55: slot[s] <= recv.
- Opcode 0x5A: kout <= slot[s], key_sel <= s, key_ready pulses in the following cycle.
REQ-020 0xA5 with core_busy=0 SHALL load dout <= din, pulse din_ready the next cycle, enter START_WAIT, and pulse start exactly one cycle after din_ready.
REQ-021 0xA5 with core_busy=1 SHALL pulse err, leave dout unchanged, and stay in IDLE.
REQ-022 Bytes accepted in START_WAIT SHALL be dropped and SHALL pulse err.
REQ-023 kout, dout, key_sel, enc_dec and the slots SHALL hold their value until explicitly rewritten.
REQ-024 When a store to slot[s] and a 0x5A on the same slot coincide, the read SHALL use the pre-write value.

Reset
REQ-025 On rst_h, the module SHALL reset as follows:
- FSM to IDLE; cnt to DATA_BYTES-1.
- recv, din, all slots, kout, dout and key_sel to 0.
- enc_dec to 0; all pulse outputs to 0.
- Edge-detect history to 0.
REQ-026 Assertion of rst_h mid-frame SHALL abort the frame with no partial write to din, the slots, kout or dout.
REQ-027 rst_sw SHALL NOT reset this module.

Configuration
REQ-028 With CMD_TIMEOUT_EN defined, a counter SHALL clear on every accepted byte and count in RECV and SLOT_WAIT; on reaching TIMEOUT_CYC it SHALL force IDLE and pulse err, leaving bytes already written in recv in place.
REQ-029 Without CMD_TIMEOUT_EN, RECV and SLOT_WAIT SHALL wait indefinitely and no timeout logic SHALL exist.

Structure
REQ-030 Package cmd_pkg SHALL hold the opcode constants and the FSM state enum.
REQ-031 Sub-module cmd_edge_det SHALL produce the single-cycle accept pulse from cmd_rdy.

Verification
REQ-032 Key load: send 0x50 plus bytes 0x00..0x0F, then 0x55 0x02, then 0x5A 0x02 -> key_ready pulses once, kout=0x000102..0F, key_sel=2.
REQ-033 Data path: send 0x50 plus 16x0xAA, then 0xA0, then 0xA5 with core_busy=0 -> dout=all 0xAA, din_ready pulse, start pulse exactly 1 cycle later.
REQ-034 Busy and illegal input: 0xA5 with core_busy=1 -> err pulse, no din_ready, dout unchanged; opcode 0x33 -> err pulse; 0x5A 0x07 with NUM_SLOTS=4 -> err pulse, kout unchanged.
REQ-035 Mode and soft reset: 0x0A -> enc_dec=1; then 0x00 -> rst_sw pulses one cycle and enc_dec=0.
REQ-036 Reset mid-frame: assert rst_h after 5 of 16 bytes -> all outputs 0 and state IDLE; a following full frame is received correctly.
REQ-037 Timeout, under CMD_TIMEOUT_EN with TIMEOUT_CYC=100: send 0x50 plus 3 bytes, then idle 100 cycles -> err pulse, FSM in IDLE, next 0x05 accepted normally.
